// File: rtl/cpu_types_pkg.sv
// Shared types for the memory side of the pipelined MIPS core.
//   word_t      : 32-bit data/address word
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : mem_arbiter grant state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and the
// data stage. Data has priority; after DSTREAK_MAX consecutive data grants
// with a fetch pending, the fetch is forced through. Each access is followed
// by a one-cycle IDLE bubble.
//
// Ports:
//   CLK, nRST                        clock (rising edge), async active-low reset
//   iREN, iaddr / iwait, iload       instruction requester
//   dREN, dWEN, daddr, dstore /
//   dwait, dload                     data requester (dWEN wins over dREN)
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate     RAM port
//   arb_err                          registered one-cycle pulse on RAM ERROR
//                                    (or timeout); appears the cycle after
//                                    the failing grant cycle
//
// Build option: define ARB_TIMEOUT_EN to abort a grant that has been open for
// TIMEOUT_CYC cycles without completing. The owner's wait stays high so the
// requester simply retries.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no RAM request driven; arbitration decided at the clock edge
// IGRANT | instruction fetch owns the RAM port
// DGRANT | data access owns the RAM port
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    localparam int STREAK_W = $clog2(DSTREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(DSTREAK_MAX);

    generate
        if (DSTREAK_MAX < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
            $error("mem_arbiter: needs DSTREAK_MAX >= 1 and TIMEOUT_CYC >= 2");
        end
    endgenerate

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_next;
    logic                arb_err_next;
    ramstate_t           ram_st;
    logic                d_req;
    logic                owner_req;
    logic                ram_end;
    logic                finish;
    logic                tmo_hit;

    assign ram_st  = ramstate_t'(ramstate);
    assign d_req   = dREN | dWEN;
    // ERROR ends the access just like ACCESS does; only arb_err differs.
    assign ram_end = (ram_st == ACCESS) || (ram_st == ERROR);

    always_comb begin
        owner_req = 1'b0;
        case (state)
            IGRANT:  owner_req = iREN;
            DGRANT:  owner_req = d_req;
            default: owner_req = 1'b0;
        endcase
    end

    assign finish = owner_req & ram_end;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    // Counts grant cycles already spent; zero on the first grant cycle.
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = owner_req & ~ram_end & (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        streak_next  = streak;
        arb_err_next = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && (!iREN || streak < STREAK_SAT)) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (finish) begin
                    state_next   = IDLE;
                    arb_err_next = (ram_st == ERROR);
                    if (state == IGRANT) begin
                        streak_next = '0;
                    end else if (iREN && streak < STREAK_SAT) begin
                        streak_next = streak + 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next   = IDLE;
                    arb_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fetch-free cycle means nobody is being starved.
        if (!iREN) begin
            streak_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            streak  <= '0;
            arb_err <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            state   <= state_next;
            streak  <= streak_next;
            arb_err <= arb_err_next;
`ifdef ARB_TIMEOUT_EN
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
            end
            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
            end
            default: ;
        endcase
    end

    assign iwait = iREN  & ~((state == IGRANT) & ram_end);
    assign dwait = d_req & ~((state == DGRANT) & ram_end);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, all compared every cycle against a behavioural model of
// the arbitration rules.
module tb_mem_arbiter;

    localparam int DMAX = 4;
    localparam int TCYC = 8;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        arb_err;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DSTREAK_MAX(DMAX), .TIMEOUT_CYC(TCYC)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .arb_err(arb_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), how many
    // data grants in a row the fetch has waited through, how long the current
    // grant has been open, and whether an error pulse is due this cycle.
    int m_owner;
    int m_streak;
    int m_gcyc;
    bit m_err;
    bit i_done_last;
    bit d_done_last;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_streak = 0;
        m_gcyc   = 0;
        m_err    = 1'b0;
    endtask

    task automatic drive_idle();
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;
    endtask

    // Called right after a falling edge with this cycle's inputs applied.
    task automatic settle();
        bit          dreq;
        bit          ends;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        #1;
        dreq    = dREN || dWEN;
        ends    = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
        e_iwait = iREN && !(m_owner == 1 && ends);
        e_dwait = dreq && !(m_owner == 2 && ends);
        e_ren   = (m_owner == 1) ? iREN : (m_owner == 2) ? (dREN && !dWEN) : 1'b0;
        e_wen   = (m_owner == 2) && dWEN;
        e_addr  = (m_owner == 1) ? iaddr : (m_owner == 2) ? daddr : 32'h0;
        e_store = (m_owner == 2) ? dstore : 32'h0;
        check_val("iwait",    iwait,    e_iwait);
        check_val("dwait",    dwait,    e_dwait);
        check_val("ramREN",   ramREN,   e_ren);
        check_val("ramWEN",   ramWEN,   e_wen);
        check_val("ramaddr",  ramaddr,  e_addr);
        check_val("ramstore", ramstore, e_store);
        check_val("iload",    iload,    (m_owner == 1) ? ramload : 32'h0);
        check_val("dload",    dload,    (m_owner == 2) ? ramload : 32'h0);
        check_val("arb_err",  arb_err,  m_err);
        i_done_last = iREN && !e_iwait;
        d_done_last = dreq && !e_dwait;
    endtask

    // Applies the clock edge to the model, then waits for the next falling edge.
    task automatic advance();
        bit dreq;
        bit req;
        bit ends;
        int nxt;
        dreq  = dREN || dWEN;
        ends  = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
        req   = (m_owner == 1) ? iREN : (m_owner == 2) ? dreq : 1'b0;
        m_err = 1'b0;
        nxt   = m_owner;
        if (m_owner == 0) begin
            m_gcyc = 0;
            if (dreq && (!iREN || m_streak < DMAX)) nxt = 2;
            else if (iREN) nxt = 1;
        end else if (!req) begin
            nxt = 0;
        end else if (ends) begin
            nxt   = 0;
            m_err = (ramstate == RS_ERROR);
            if (m_owner == 1) m_streak = 0;
            else if (iREN && m_streak < DMAX) m_streak = m_streak + 1;
        end else begin
            m_gcyc = m_gcyc + 1;
`ifdef ARB_TIMEOUT_EN
            if (m_gcyc == TCYC) begin
                nxt   = 0;
                m_err = 1'b1;
            end
`endif
        end
        if (!iREN) m_streak = 0;
        m_owner = nxt;
        @(negedge CLK);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no end expected $finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        int d_at_i;
        bit i_seen;
        bit i_ok;
        bit d_ok;
        int r;

        drive_idle();
        nRST = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        // Reset in the middle of a data grant while the RAM is busy.
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h5555_AAAA; ramstate = RS_BUSY;
        cycle();
        settle();
        check_val("rst_pre_wen", ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check_val("rst_wen",   ramWEN,  1'b0);
        check_val("rst_ren",   ramREN,  1'b0);
        check_val("rst_addr",  ramaddr, 32'h0);
        check_val("rst_err",   arb_err, 1'b0);
        check_val("rst_dwait", dwait,   1'b1);
        check_val("rst_streak", 32'(dut.streak), 32'h0);
        model_reset();
        drive_idle();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Instruction only, two BUSY cycles then ACCESS.
        iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = RS_FREE;
        settle(); check_val("io_c0_ren", ramREN, 1'b0); advance();
        ramstate = RS_BUSY;
        settle(); check_val("io_c1_ren", ramREN, 1'b1);
        check_val("io_c1_addr", ramaddr, 32'h40); check_val("io_c1_iwait", iwait, 1'b1); advance();
        settle(); check_val("io_c2_iwait", iwait, 1'b1); advance();
        ramstate = RS_ACCESS; ramload = 32'h2108_0004;
        settle(); check_val("io_c3_iwait", iwait, 1'b0);
        check_val("io_c3_iload", iload, 32'h2108_0004); advance();
        drive_idle();
        settle(); check_val("io_c4_ren", ramREN, 1'b0); advance();

        // Contention: data write first, bubble, then the fetch.
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        settle(); check_val("ct_idle_wen", ramWEN, 1'b0); advance();
        ramstate = RS_BUSY;
        settle(); check_val("ct_wen", ramWEN, 1'b1); check_val("ct_store", ramstore, 32'hDEAD_BEEF);
        check_val("ct_daddr", ramaddr, 32'h100); check_val("ct_iwait", iwait, 1'b1); advance();
        ramstate = RS_ACCESS;
        settle(); check_val("ct_dwait_done", dwait, 1'b0); check_val("ct_iwait_hold", iwait, 1'b1); advance();
        dWEN = 1'b0; ramstate = RS_FREE;
        settle(); check_val("ct_bubble_ren", ramREN, 1'b0); check_val("ct_bubble_wen", ramWEN, 1'b0); advance();
        ramstate = RS_ACCESS; ramload = 32'h0000_1234;
        settle(); check_val("ct_igrant_ren", ramREN, 1'b1); check_val("ct_igrant_addr", ramaddr, 32'h44);
        check_val("ct_iload", iload, 32'h1234); advance();
        drive_idle();
        cycle();

        // Starvation bound: fetch held while five data reads queue up.
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300; ramstate = RS_ACCESS;
        dcount = 0; d_at_i = -1; i_seen = 1'b0;
        for (int c = 0; c < 60 && dcount < 5; c++) begin
            ramload = $urandom;
            settle();
            d_ok = dREN && !dwait;
            i_ok = iREN && !iwait;
            advance();
            if (d_ok) begin
                dcount++;
                daddr = daddr + 32'h4;
                if (dcount == 5) dREN = 1'b0;
            end
            if (i_ok && !i_seen) begin
                i_seen = 1'b1;
                d_at_i = dcount;
                iREN   = 1'b0;
            end
        end
        check_val("starve_d_before_i", 32'(d_at_i), 32'd4);
        check_val("starve_d_total", 32'(dcount), 32'd5);
        drive_idle();
        cycle();

        // RAM error during a data grant.
        dREN = 1'b1; daddr = 32'h500;
        cycle();
        ramstate = RS_ERROR;
        settle(); check_val("er_dwait", dwait, 1'b0); check_val("er_err_early", arb_err, 1'b0); advance();
        drive_idle();
        settle(); check_val("er_err_pulse", arb_err, 1'b1); check_val("er_idle_ren", ramREN, 1'b0); advance();
        settle(); check_val("er_err_clear", arb_err, 1'b0); advance();

        // Fetch withdrawn while the RAM is busy.
        iREN = 1'b1; iaddr = 32'h600; ramstate = RS_BUSY;
        settle(); check_val("wd_idle_iwait", iwait, 1'b1); advance();
        settle(); check_val("wd_grant_ren", ramREN, 1'b1); check_val("wd_grant_iwait", iwait, 1'b1); advance();
        iREN = 1'b0;
        settle(); check_val("wd_drop_err", arb_err, 1'b0); advance();
        iREN = 1'b1;
        settle(); check_val("wd_back_idle", ramREN, 1'b0); check_val("wd_back_iwait", iwait, 1'b1); advance();
        settle(); check_val("wd_regrant", ramREN, 1'b1); advance();
        ramstate = RS_ACCESS;
        settle(); check_val("wd_done", iwait, 1'b0); advance();
        drive_idle();
        cycle();

`ifdef ARB_TIMEOUT_EN
        // Grant held BUSY until the timeout aborts it; the fetch then retries.
        iREN = 1'b1; iaddr = 32'h700; ramstate = RS_BUSY;
        cycle();
        for (int g = 1; g <= TCYC; g++) begin
            settle();
            check_val("to_ren", ramREN, 1'b1);
            check_val("to_iwait", iwait, 1'b1);
            check_val("to_err_quiet", arb_err, 1'b0);
            advance();
        end
        settle(); check_val("to_err_pulse", arb_err, 1'b1); check_val("to_idle_ren", ramREN, 1'b0);
        check_val("to_iwait_hold", iwait, 1'b1); advance();
        settle(); check_val("to_reenter", ramREN, 1'b1); advance();
        ramstate = RS_ACCESS;
        settle(); check_val("to_done", iwait, 1'b0); advance();
        drive_idle();
        cycle();
`endif

        // Randomized traffic.
        i_done_last = 1'b0;
        d_done_last = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (iREN && !i_done_last) begin
                if ($urandom_range(0, 99) < 3) iREN = 1'b0;
            end else begin
                iREN  = ($urandom_range(0, 99) < 60);
                iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if ((dREN || dWEN) && !d_done_last) begin
                if ($urandom_range(0, 99) < 3) begin
                    dREN = 1'b0;
                    dWEN = 1'b0;
                end
            end else begin
                r      = $urandom_range(0, 99);
                dREN   = (r < 25) || (r >= 45 && r < 50);
                dWEN   = (r >= 25 && r < 50);
                daddr  = $urandom & 32'hFFFF_FFFC;
                dstore = $urandom;
            end
            r = $urandom_range(0, 99);
            ramstate = (r < 10) ? RS_FREE : (r < 50) ? RS_BUSY : (r < 90) ? RS_ACCESS : RS_ERROR;
            ramload  = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Schedules the single shared RAM port between the instruction fetch requester and the data requester of the pipelined MIPS core.
- Sits between the fetch/memory stages and the RAM model.
- Holds the hazard-visible iwait/dwait stall signals high until the owning access completes.
- Data has priority; a streak limit bounds instruction starvation.

Parameters:
- DSTREAK_MAX, 4: maximum consecutive data grants while iREN is pending before instruction is forced.
- TIMEOUT_CYC, 64: cycles a grant may stay open before abort (only with ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  instruction stall
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data stall
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- arb_err  out  1  one-cycle pulse on RAM error or timeout

Behaviour:
- States: IDLE, IGRANT, DGRANT. The state register and counters reset asynchronously on nRST low.
- Reset values:
  - state = IDLE, streak = 0, arb_err = 0.
  - ramREN, ramWEN, ramaddr and ramstore = 0.
  - iwait = iREN and dwait = dREN|dWEN, because these are combinational.
- IDLE arbitration, decided at the rising edge:
  - If (dREN|dWEN) and (!iREN or streak < DSTREAK_MAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- IDLE drives no RAM request; this gives a one-cycle bubble between accesses.
- RAM drive:
  - IGRANT: ramREN = iREN, ramWEN = 0, ramaddr = iaddr.
  - DGRANT: ramREN = dREN & !dWEN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
  - dWEN takes precedence over dREN.
  - All RAM outputs are combinational from state and the live inputs.
  - ramstore = 0 outside DGRANT.
- Completion:
  - Completion occurs in the owner's grant state when ramstate == ACCESS.
  - The owner's wait goes low for exactly that cycle.
  - The next state is IDLE.
- Wait rules:
  - iwait = iREN & !(IGRANT & ramstate==ACCESS).
  - dwait = (dREN|dWEN) & !(DGRANT & ramstate==ACCESS).
  - The non-owner stays stalled.
- Read data:
  - iload = ramload in IGRANT, else 0.
  - dload = ramload in DGRANT, else 0.
- ramstate == ERROR while granted:
  - Owner's wait goes low for that cycle.
  - arb_err = 1 for one cycle.
  - Next state is IDLE; streak is updated as for a normal completion.
- Request withdrawn while granted: the owner's request drops before completion; next state is IDLE, no wait drop, no streak change.
- ramstate FREE or BUSY while granted: hold the state; the requester must hold its address and data.
- Streak counter (width $clog2(DSTREAK_MAX+1)):
  - Increments on data completion if iREN = 1, saturating at DSTREAK_MAX.
  - Clears on instruction completion, and on any cycle with iREN = 0.
- Simultaneous iREN and dREN/dWEN in IDLE with streak == DSTREAK_MAX: instruction wins.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A timeout counter clears on entry to a grant state and increments each cycle in IGRANT or DGRANT.
  - When it reaches TIMEOUT_CYC - 1 without completion: pulse arb_err, go to IDLE, keep the owner's wait high so the requester retries.
  - On timeout, streak is unchanged.
- When undefined: no counter, no timeout; arb_err is driven only by ERROR.

Decomposition:
- cpu_types_pkg holds word_t and ramstate_t (FREE, BUSY, ACCESS, ERROR), and a new arb_state_t enum (IDLE, IGRANT, DGRANT).
- No sub-module; a single flat module with one always_ff for state, streak and timeout, and always_comb blocks for next state and outputs.

Test Plan:
- Reset: nRST low mid-DGRANT with ramstate = BUSY -> state IDLE immediately, ramWEN = 0, arb_err = 0, streak = 0.
- Instruction only: iREN = 1, iaddr = 0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with ramload = 0x2108_0004.
  - Required: ramREN = 1 from cycle 1; iwait low on cycle 3 only; iload = 0x2108_0004.
- Contention: iREN and dWEN both high, daddr = 0x100, dstore = 0xDEAD_BEEF.
  - Required: DGRANT first with ramWEN = 1 and ramstore = 0xDEAD_BEEF, iwait held high; after completion, one IDLE cycle, then IGRANT.
- Starvation: iREN held with 5 back-to-back data requests, DSTREAK_MAX = 4.
  - Required: 4 data completions, then the instruction is granted before the 5th data request.
- Error and withdraw:
  - ramstate = ERROR in DGRANT -> dwait low and arb_err = 1 for one cycle, then IDLE.
  - iREN dropped in IGRANT while BUSY -> IDLE, no iwait pulse.
- ARB_TIMEOUT_EN with TIMEOUT_CYC = 8: ramstate held BUSY in IGRANT.
  - Required: arb_err pulses on the 8th grant cycle, state returns to IDLE, iwait stays high, and IGRANT is re-entered.
